// File: rtl/xbar_pkg.sv
// Shared crossbar sizing and grant/index conversion helpers.
// Crossbar port count and data width used by the response path.
package xbar_pkg;
    localparam int NUM_M  = 16;
    localparam int IDX_W  = $clog2(NUM_M);
    localparam int DATA_W = 64;

    function automatic logic [IDX_W-1:0] oh_to_idx(input logic [NUM_M-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_M; i++)
            if (oh[i]) idx = idx | IDX_W'(i);
        return idx;
    endfunction

    function automatic logic [NUM_M-1:0] idx_to_oh(input logic [IDX_W-1:0] idx);
        logic [NUM_M-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction
endpackage

// File: rtl/xbar_resp_router_if.sv
// Arbiter/slave/master-response signals of the crossbar response router.
interface xbar_resp_router_if #(
    parameter int NUM_M  = 16,
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
);
    logic [NUM_M-1:0]         grant;
    logic                     s_valid;
    logic                     s_ready;
    logic                     s_rvalid;
    logic [DATA_W-1:0]        s_rdata;
    logic                     s_rerr;
    logic [NUM_M-1:0]         m_rvalid;
    logic [DATA_W-1:0]        m_rdata;
    logic                     m_rerr;
    logic                     full;
    logic [$clog2(DEPTH):0]   outstanding;
    logic                     proto_err;

    // Router side
    modport slave (
        input  grant, s_ready, s_rvalid, s_rdata, s_rerr,
        output s_valid, m_rvalid, m_rdata, m_rerr, full, outstanding, proto_err
    );

    // Environment side (arbiter, slave, masters)
    modport master (
        output grant, s_ready, s_rvalid, s_rdata, s_rerr,
        input  s_valid, m_rvalid, m_rdata, m_rerr, full, outstanding, proto_err
    );
endinterface

// File: rtl/xbar_id_fifo.sv
// In-order FIFO of master indices for requests awaiting a slave response.
module xbar_id_fifo #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [IDX_W-1:0]       push_idx,
    input  logic                   pop,
    output logic [IDX_W-1:0]       pop_idx,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    // Power-of-two depth: pointers wrap for free on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_idx;
    end

    assign pop_idx = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
endmodule

// File: rtl/xbar_resp_router.sv
// Tracks which master issued each slave request and steers in-order
// slave responses back to that master one cycle later.
module xbar_resp_router
    import xbar_pkg::*;
#(
    parameter int NUM_M  = xbar_pkg::NUM_M,
    parameter int DEPTH  = 4,
    parameter int DATA_W = xbar_pkg::DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    xbar_resp_router_if.slave bus
);
    localparam int ID_W = $clog2(NUM_M);

    logic            grant_one, grant_multi;
    logic            push, pop, fifo_full, fifo_empty;
    logic [ID_W-1:0] pop_idx;

    assign grant_one   = (bus.grant != '0) &&
                         ((bus.grant & (bus.grant - NUM_M'(1))) == '0);
    assign grant_multi = (bus.grant != '0) && !grant_one;

    // full comes from the registered count, so a same-cycle pop never frees a slot.
    assign bus.s_valid = grant_one && !fifo_full;
    assign push        = bus.s_valid && bus.s_ready;
    assign pop         = bus.s_rvalid && !fifo_empty;

    xbar_id_fifo #(.DEPTH(DEPTH), .IDX_W(ID_W)) u_id_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_idx (oh_to_idx(bus.grant)),
        .pop      (pop),
        .pop_idx  (pop_idx),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (bus.outstanding)
    );

    assign bus.full = fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.m_rvalid  <= '0;
            bus.m_rdata   <= '0;
            bus.m_rerr    <= 1'b0;
            bus.proto_err <= 1'b0;
        end else begin
            bus.m_rvalid <= pop ? idx_to_oh(pop_idx) : '0;
            if (pop) begin
                bus.m_rdata <= bus.s_rdata;
                bus.m_rerr  <= bus.s_rerr;
            end
            // Stray response or multi-hot grant latch until reset.
            if ((bus.s_rvalid && fifo_empty) || grant_multi)
                bus.proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_xbar_resp_router.sv
// Randomised and directed checks of xbar_resp_router against a queue model.
module tb_xbar_resp_router;
    localparam int NUM_M  = 16;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xbar_resp_router_if #(.NUM_M(NUM_M), .DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    xbar_resp_router #(.NUM_M(NUM_M), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: queue of master numbers in issue order.
    int                q[$];
    bit                m_perr;
    logic [NUM_M-1:0]  e_mrv;
    logic [DATA_W-1:0] e_md;
    logic              e_me;
    bit                e_sval;

    function automatic int idx_of(input logic [NUM_M-1:0] g);
        for (int i = 0; i < NUM_M; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic apply(input logic [NUM_M-1:0] g, input bit rdy, input bit rv,
                         input logic [DATA_W-1:0] d, input bit e);
        bus.grant = g; bus.s_ready = rdy; bus.s_rvalid = rv;
        bus.s_rdata = d; bus.s_rerr = e;
        e_sval = ($countones(g) == 1) && (q.size() < DEPTH);
        #1;
    endtask

    // Advance one cycle and update the model from the inputs applied.
    task automatic tick();
        bit psh, pp;
        int popped;
        psh = e_sval && bus.s_ready;
        pp  = bus.s_rvalid && (q.size() > 0);
        if (bus.s_rvalid && q.size() == 0) m_perr = 1;
        if ($countones(bus.grant) > 1) m_perr = 1;
        e_mrv = '0;
        if (pp) begin
            popped = q.pop_front();
            e_mrv  = NUM_M'(1) << popped;
            e_md   = bus.s_rdata;
            e_me   = bus.s_rerr;
        end
        if (psh) q.push_back(idx_of(bus.grant));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        apply('0, 0, 0, '0, 0);
        rst = 1'b1;
        q.delete(); m_perr = 0; e_mrv = '0; e_md = '0; e_me = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.outstanding !== '0) $display("FAIL reset_outstanding: got %0d want 0", bus.outstanding); else passed++;
        total++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.full); else passed++;
        total++; if (bus.m_rvalid !== '0) $display("FAIL reset_m_rvalid: got %h want 0", bus.m_rvalid); else passed++;
        total++; if (bus.m_rdata !== '0) $display("FAIL reset_m_rdata: got %h want 0", bus.m_rdata); else passed++;
        total++; if (bus.m_rerr !== 1'b0) $display("FAIL reset_m_rerr: got %b want 0", bus.m_rerr); else passed++;
        total++; if (bus.proto_err !== 1'b0) $display("FAIL reset_proto_err: got %b want 0", bus.proto_err); else passed++;
    endtask

    task automatic test_single();
        do_reset();
        apply(16'h0004, 1, 0, '0, 0);
        total++; if (bus.s_valid !== 1'b1) $display("FAIL single_s_valid: got %b want 1", bus.s_valid); else passed++;
        tick();
        total++; if (bus.outstanding !== 1) $display("FAIL single_outstanding1: got %0d want 1", bus.outstanding); else passed++;
        apply('0, 0, 0, '0, 0); tick();
        apply('0, 0, 1, 64'hDEAD_BEEF, 0); tick();
        total++; if (bus.m_rvalid !== 16'h0004) $display("FAIL single_m_rvalid: got %h want 0004", bus.m_rvalid); else passed++;
        total++; if (bus.m_rdata !== 64'hDEAD_BEEF) $display("FAIL single_m_rdata: got %h want deadbeef", bus.m_rdata); else passed++;
        total++; if (bus.outstanding !== 0) $display("FAIL single_outstanding0: got %0d want 0", bus.outstanding); else passed++;
        apply('0, 0, 0, '0, 0); tick();
        total++; if (bus.m_rvalid !== '0) $display("FAIL single_strobe_clear: got %h want 0", bus.m_rvalid); else passed++;
        total++; if (bus.m_rdata !== 64'hDEAD_BEEF) $display("FAIL single_rdata_hold: got %h want deadbeef", bus.m_rdata); else passed++;
    endtask

    task automatic test_full();
        int ids[4] = '{0, 5, 15, 3};
        logic [NUM_M-1:0] want[4] = '{16'h0001, 16'h0020, 16'h8000, 16'h0008};
        do_reset();
        foreach (ids[i]) begin apply(NUM_M'(1) << ids[i], 1, 0, '0, 0); tick(); end
        apply(16'h0080, 1, 0, '0, 0);
        total++; if (bus.full !== 1'b1) $display("FAIL full_flag: got %b want 1", bus.full); else passed++;
        total++; if (bus.s_valid !== 1'b0) $display("FAIL full_s_valid: got %b want 0", bus.s_valid); else passed++;
        tick();
        // A pop while full must not let the waiting grant issue.
        apply(16'h0080, 1, 1, 64'h11, 0);
        total++; if (bus.s_valid !== 1'b0) $display("FAIL full_pop_s_valid: got %b want 0", bus.s_valid); else passed++;
        tick();
        total++; if (bus.m_rvalid !== want[0]) $display("FAIL full_resp0: got %h want %h", bus.m_rvalid, want[0]); else passed++;
        for (int i = 1; i < 4; i++) begin
            apply('0, 0, 1, 64'(i), i[0]); tick();
            total++; if (bus.m_rvalid !== want[i]) $display("FAIL full_resp%0d: got %h want %h", i, bus.m_rvalid, want[i]); else passed++;
            total++; if (bus.m_rerr !== i[0]) $display("FAIL full_rerr%0d: got %b want %b", i, bus.m_rerr, i[0]); else passed++;
        end
        total++; if (bus.outstanding !== 0) $display("FAIL full_drained: got %0d want 0", bus.outstanding); else passed++;
    endtask

    task automatic test_simul();
        do_reset();
        apply(16'h0004, 1, 0, '0, 0); tick();
        apply(16'h0200, 1, 0, '0, 0); tick();
        apply(16'h0800, 1, 1, 64'hABCD, 1); tick();
        total++; if (bus.outstanding !== 2) $display("FAIL simul_outstanding: got %0d want 2", bus.outstanding); else passed++;
        total++; if (bus.m_rvalid !== 16'h0004) $display("FAIL simul_oldest: got %h want 0004", bus.m_rvalid); else passed++;
        apply('0, 0, 1, 64'h1, 0); tick();
        total++; if (bus.m_rvalid !== 16'h0200) $display("FAIL simul_second: got %h want 0200", bus.m_rvalid); else passed++;
        apply('0, 0, 1, 64'h2, 0); tick();
        total++; if (bus.m_rvalid !== 16'h0800) $display("FAIL simul_third: got %h want 0800", bus.m_rvalid); else passed++;
    endtask

    task automatic test_grant_change();
        do_reset();
        apply(16'h0010, 0, 0, '0, 0); tick();
        apply(16'h0040, 0, 0, '0, 0); tick();
        apply(16'h0200, 1, 0, '0, 0); tick();
        total++; if (bus.outstanding !== 1) $display("FAIL gchg_outstanding: got %0d want 1", bus.outstanding); else passed++;
        apply('0, 0, 1, 64'h5, 0); tick();
        total++; if (bus.m_rvalid !== 16'h0200) $display("FAIL gchg_m_rvalid: got %h want 0200", bus.m_rvalid); else passed++;
    endtask

    task automatic test_multi();
        do_reset();
        apply(16'h0011, 1, 0, '0, 0);
        total++; if (bus.s_valid !== 1'b0) $display("FAIL multi_s_valid: got %b want 0", bus.s_valid); else passed++;
        tick();
        total++; if (bus.proto_err !== 1'b1) $display("FAIL multi_proto_err: got %b want 1", bus.proto_err); else passed++;
        total++; if (bus.outstanding !== 0) $display("FAIL multi_no_push: got %0d want 0", bus.outstanding); else passed++;
    endtask

    task automatic test_stray();
        do_reset();
        apply('0, 0, 1, 64'h77, 0); tick();
        total++; if (bus.m_rvalid !== '0) $display("FAIL stray_m_rvalid: got %h want 0", bus.m_rvalid); else passed++;
        total++; if (bus.proto_err !== 1'b1) $display("FAIL stray_proto_err: got %b want 1", bus.proto_err); else passed++;
        apply(16'h0002, 1, 0, '0, 0); tick();
        apply('0, 0, 1, 64'h8, 0); tick();
        total++; if (bus.proto_err !== 1'b1) $display("FAIL stray_sticky: got %b want 1", bus.proto_err); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin apply(NUM_M'(1) << (i + 1), 1, 0, '0, 0); tick(); end
        total++; if (bus.outstanding !== 3) $display("FAIL rmid_pre: got %0d want 3", bus.outstanding); else passed++;
        do_reset();
        total++; if (bus.outstanding !== 0) $display("FAIL rmid_flush: got %0d want 0", bus.outstanding); else passed++;
        apply('0, 0, 1, 64'h9, 0); tick();
        total++; if (bus.m_rvalid !== '0) $display("FAIL rmid_m_rvalid: got %h want 0", bus.m_rvalid); else passed++;
        total++; if (bus.proto_err !== 1'b1) $display("FAIL rmid_proto_err: got %b want 1", bus.proto_err); else passed++;
        total++; if (bus.outstanding !== 0) $display("FAIL rmid_outstanding: got %0d want 0", bus.outstanding); else passed++;
    endtask

    task automatic test_random();
        logic [NUM_M-1:0]  g;
        logic [DATA_W-1:0] d;
        int sel;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 20)      g = '0;
            else if (sel < 97) g = NUM_M'(1) << $urandom_range(0, NUM_M - 1);
            else               g = NUM_M'(3) << $urandom_range(0, NUM_M - 2);
            d = {$urandom, $urandom};
            apply(g, $urandom_range(0, 1), ($urandom_range(0, 9) < 4), d, $urandom_range(0, 1));
            total++; if (bus.s_valid !== e_sval) $display("FAIL rnd_s_valid @%0d: got %b want %b", n, bus.s_valid, e_sval); else passed++;
            tick();
            total++;
            if (bus.m_rvalid !== e_mrv || bus.m_rdata !== e_md || bus.m_rerr !== e_me ||
                bus.outstanding !== q.size() || bus.full !== (q.size() == DEPTH) || bus.proto_err !== m_perr)
                $display("FAIL rnd_state @%0d: got rv=%h d=%h e=%b out=%0d full=%b perr=%b want rv=%h d=%h e=%b out=%0d full=%b perr=%b",
                         n, bus.m_rvalid, bus.m_rdata, bus.m_rerr, bus.outstanding, bus.full, bus.proto_err,
                         e_mrv, e_md, e_me, q.size(), (q.size() == DEPTH), m_perr);
            else passed++;
        end
    endtask

    initial begin
        bus.grant = '0; bus.s_ready = 0; bus.s_rvalid = 0; bus.s_rdata = '0; bus.s_rerr = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_full();
        test_simul();
        test_grant_change();
        test_multi();
        test_stray();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
